// File: rtl/p2s_multi.sv
// Multi-lane parallel-to-serial transmitter: NUM_CH words shifted out in lockstep
// under one bit counter, with a one-deep holding buffer for gapless back-to-back frames.
module p2s_multi #(
    parameter int unsigned DATA_W    = 40,
    parameter int unsigned NUM_CH    = 2,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic                     SCLK,
    input  logic                     CLR,
    input  logic                     LOAD,
    input  logic [NUM_CH*DATA_W-1:0] PDATAIN,
    output logic [NUM_CH-1:0]        DATAOUT,
    output logic                     OutReady,
    output logic                     FRAME_START,
    output logic                     BUF_FULL,
    output logic                     OVERRUN
);

    localparam int unsigned CNT_W   = $clog2(DATA_W);
    localparam int unsigned BUS_W   = NUM_CH * DATA_W;
    localparam int unsigned OUT_BIT = LSB_FIRST ? 0 : DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BUS_W-1:0]   shift_q;
    logic [BUS_W-1:0]   hold_q;
    logic [BUS_W-1:0]   shift_adv;
    logic               hold_valid;

    // Each lane moves its next bit into the OUT_BIT position.
    always_comb begin
        shift_adv = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (LSB_FIRST) begin
                shift_adv[c*DATA_W +: DATA_W] = shift_q[c*DATA_W +: DATA_W] >> 1;
            end else begin
                shift_adv[c*DATA_W +: DATA_W] = shift_q[c*DATA_W +: DATA_W] << 1;
            end
        end
    end

    always_ff @(posedge SCLK) begin
        if (CLR) begin
            state       <= IDLE;
            cnt         <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_valid  <= 1'b0;
            FRAME_START <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            FRAME_START <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        shift_q     <= PDATAIN;
                        cnt         <= '0;
                        state       <= SHIFT;
                        FRAME_START <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        // End of word: hold has priority, then a fresh LOAD, else go idle.
                        if (hold_valid) begin
                            shift_q     <= hold_q;
                            cnt         <= '0;
                            FRAME_START <= 1'b1;
                            if (LOAD) begin
                                hold_q <= PDATAIN;
                            end else begin
                                hold_valid <= 1'b0;
                            end
                        end else if (LOAD) begin
                            shift_q     <= PDATAIN;
                            cnt         <= '0;
                            FRAME_START <= 1'b1;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        shift_q <= shift_adv;
                        cnt     <= cnt + CNT_W'(1);
                        if (LOAD) begin
                            if (hold_valid) begin
                                OVERRUN <= 1'b1;
                            end else begin
                                hold_q     <= PDATAIN;
                                hold_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OutReady = (state == SHIFT);
    assign BUF_FULL = hold_valid;

    // Lanes are masked to zero whenever no word is being sent.
    always_comb begin
        DATAOUT = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            DATAOUT[c] = OutReady & shift_q[c*DATA_W + OUT_BIT];
        end
    end

endmodule

// File: tb/tb_p2s_multi.sv
// Self-checking bench for p2s_multi: directed scenarios plus random traffic against
// a queue-based frame model; a second small LSB-first instance checks bit ordering.
module tb_p2s_multi;

    localparam int DW = 40;
    localparam int NC = 2;
    localparam int BW = DW * NC;

    logic SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    logic          CLR;
    logic          LOAD;
    logic [BW-1:0] PDATAIN;
    logic [NC-1:0] DATAOUT;
    logic          OutReady;
    logic          FRAME_START;
    logic          BUF_FULL;
    logic          OVERRUN;

    logic       load_b;
    logic [7:0] pdata_b;
    logic [0:0] dout_b;
    logic       rdy_b;
    logic       fs_b;
    logic       bf_b;
    logic       ov_b;

    p2s_multi #(.DATA_W(DW), .NUM_CH(NC), .LSB_FIRST(1'b0)) dut_a (
        .SCLK(SCLK), .CLR(CLR), .LOAD(LOAD), .PDATAIN(PDATAIN),
        .DATAOUT(DATAOUT), .OutReady(OutReady), .FRAME_START(FRAME_START),
        .BUF_FULL(BUF_FULL), .OVERRUN(OVERRUN)
    );

    p2s_multi #(.DATA_W(8), .NUM_CH(1), .LSB_FIRST(1'b1)) dut_b (
        .SCLK(SCLK), .CLR(CLR), .LOAD(load_b), .PDATAIN(pdata_b),
        .DATAOUT(dout_b), .OutReady(rdy_b), .FRAME_START(fs_b),
        .BUF_FULL(bf_b), .OVERRUN(ov_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame model: current word with bit index, plus a queue of accepted words waiting.
    bit            m_active;
    logic [BW-1:0] m_word;
    int            m_k;
    logic [BW-1:0] m_wait[$];
    bit            m_ovr;
    bit            m_fs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return BW'(r);
    endfunction

    task automatic model_step(input logic clr, input logic load, input logic [BW-1:0] data);
        if (clr) begin
            m_active = 0; m_k = 0; m_wait.delete(); m_ovr = 0; m_fs = 0; m_word = '0;
        end else if (!m_active) begin
            m_fs = load;
            if (load) begin
                m_active = 1; m_word = data; m_k = 0;
            end
        end else if (m_k == DW - 1) begin
            if (m_wait.size() > 0) begin
                m_word = m_wait.pop_front(); m_k = 0; m_fs = 1;
                if (load) m_wait.push_back(data);
            end else if (load) begin
                m_word = data; m_k = 0; m_fs = 1;
            end else begin
                m_active = 0; m_fs = 0;
            end
        end else begin
            m_k++;
            m_fs = 0;
            if (load) begin
                if (m_wait.size() == 0) m_wait.push_back(data);
                else m_ovr = 1;
            end
        end
    endtask

    task automatic check_a();
        logic [NC-1:0] exp_out;
        exp_out = '0;
        if (m_active) begin
            for (int c = 0; c < NC; c++) exp_out[c] = m_word[c*DW + DW - 1 - m_k];
        end
        check("dataout",     64'(DATAOUT),     64'(exp_out));
        check("outready",    64'(OutReady),    64'(m_active));
        check("frame_start", 64'(FRAME_START), 64'(m_fs));
        check("buf_full",    64'(BUF_FULL),    64'(m_wait.size() != 0));
        check("overrun",     64'(OVERRUN),     64'(m_ovr));
    endtask

    task automatic cycle(input logic clr, input logic load, input logic [BW-1:0] data);
        @(negedge SCLK);
        CLR = clr; LOAD = load; PDATAIN = data;
        @(posedge SCLK);
        model_step(clr, load, data);
        #1 check_a();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, rnd_word());
    endtask

    task automatic push_word(input logic [BW-1:0] d);
        cycle(1'b0, 1'b1, d);
    endtask

    initial begin
        logic [7:0] wb;
        CLR = 1'b1; LOAD = 1'b0; PDATAIN = '0;
        load_b = 1'b0; pdata_b = '0;

        // Reset state
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, rnd_word());

        // Single MSB-first frame: lane0 = 1, 38 zeros, 1; lane1 all zero
        push_word({40'h00_0000_0000, 40'h80_0000_0001});
        idle(42);

        // Back-to-back: B loaded at cnt=10
        push_word(rnd_word());
        idle(10);
        push_word(rnd_word());
        idle(85);

        // Overrun: B at cnt=5, C at cnt=6 is dropped; flag sticks until CLR
        push_word(rnd_word());
        idle(5);
        push_word(rnd_word());
        push_word(rnd_word());
        idle(85);
        cycle(1'b1, 1'b0, '0);

        // Boundary: LOAD at last bit with hold empty
        push_word(rnd_word());
        idle(DW - 1);
        push_word(rnd_word());
        idle(45);

        // Boundary: hold full and LOAD at last bit
        push_word(rnd_word());
        idle(3);
        push_word(rnd_word());
        idle(DW - 5);
        push_word(rnd_word());
        idle(DW * 2 + 5);

        // Reset mid-frame with hold full and LOAD asserted, then clean restart
        push_word(rnd_word());
        idle(3);
        push_word(rnd_word());
        idle(16);
        cycle(1'b1, 1'b1, rnd_word());
        idle(2);
        push_word(rnd_word());
        idle(45);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 24) == 0), rnd_word());
        end
        idle(DW * 2 + 4);

        // LSB-first, 8-bit, single lane: 8'hB4 goes out as 0,0,1,0,1,1,0,1
        wb = 8'hB4;
        @(negedge SCLK);
        CLR = 1'b0; LOAD = 1'b0; load_b = 1'b1; pdata_b = wb;
        for (int k = 0; k < 8; k++) begin
            @(posedge SCLK);
            #1;
            load_b = 1'b0;
            pdata_b = 8'($urandom());
            check("b_dataout", 64'(dout_b), 64'(wb[k]));
            check("b_outready", 64'(rdy_b), 64'(1));
            check("b_frame_start", 64'(fs_b), 64'(k == 0));
        end
        @(posedge SCLK);
        #1;
        check("b_idle_outready", 64'(rdy_b), 64'(0));
        check("b_idle_dataout", 64'(dout_b), 64'(0));
        check("b_buf_full", 64'(bf_b), 64'(0));
        check("b_overrun", 64'(ov_b), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p2s_multi.md
Name: p2s_multi

Overview:
Parametrised multi-lane parallel-to-serial transmitter; successor to the single 40-bit serializer on the MSDAP output path. Serialises NUM_CH channel words (e.g. left/right) in lockstep on NUM_CH serial lanes under one shared bit counter. Adds a one-deep holding buffer for gapless back-to-back frames, a selectable bit order, a frame-start strobe and a sticky overrun flag.

Parameters:
DATA_W, 40, bits per channel word (2..64)
NUM_CH, 2, number of channels / serial lanes (1..8)
LSB_FIRST, 0, 0 = MSB (bit DATA_W-1) sent first; 1 = bit 0 sent first

Ports:
SCLK  in  1  system clock; all logic on rising edge
CLR  in  1  synchronous active-high reset
LOAD  in  1  one-cycle request to accept PDATAIN
PDATAIN  in  NUM_CH*DATA_W  channel c = PDATAIN[c*DATA_W +: DATA_W]
DATAOUT  out  NUM_CH  serial bit of channel c on DATAOUT[c]
OutReady  out  1  high while a word is on the lanes
FRAME_START  out  1  high during the first bit cycle of each frame
BUF_FULL  out  1  holding buffer occupied
OVERRUN  out  1  sticky: a LOAD was dropped

Behaviour:
- Clock SCLK; reset CLR is synchronous, active-high, and has priority over all other inputs.
- State: shift regs (NUM_CH x DATA_W), hold regs (NUM_CH x DATA_W), hold_valid, bit counter cnt of width $clog2(DATA_W), state IDLE/SHIFT.
- Reset values: DATAOUT=0, OutReady=0, FRAME_START=0, BUF_FULL=0, OVERRUN=0, state=IDLE, cnt=0, shift and hold regs =0.
- All outputs are registered or decoded from registers. No combinational path from LOAD or PDATAIN to any output.
- IDLE + LOAD sampled at edge N: at edge N, PDATAIN goes to the shift regs, cnt=0, state=SHIFT.
  - From the cycle after edge N: OutReady=1, FRAME_START=1 for that single cycle, DATAOUT carries the first bit.
  - Latency LOAD to first bit: 1 edge.
- SHIFT: each edge advances one bit and cnt increments.
  - OutReady stays high for exactly DATA_W cycles per word.
  - Bit k of a frame (k=0..DATA_W-1) is word bit DATA_W-1-k when LSB_FIRST=0, and word bit k when LSB_FIRST=1.
- LOAD in SHIFT, cnt<DATA_W-1, hold empty: PDATAIN is captured into hold, hold_valid=1, BUF_FULL=1 from the next cycle.
- LOAD in SHIFT, hold full, cnt<DATA_W-1: LOAD is dropped, hold is unchanged, OVERRUN=1 from the next cycle. OVERRUN stays set until CLR.
- End of word (edge where cnt==DATA_W-1):
  - hold_valid=1: hold moves to shift, cnt=0, FRAME_START pulses. Gapless, OutReady stays 1. If LOAD is also high, PDATAIN goes to hold and BUF_FULL stays 1 (no overrun).
  - hold_valid=0 and LOAD=1: PDATAIN goes directly to shift, gapless, FRAME_START pulses.
  - hold_valid=0 and LOAD=0: state=IDLE, OutReady=0, DATAOUT=0.
- DATAOUT is forced to 0 whenever OutReady=0.
- CLR mid-frame: the transmission is aborted and all outputs return to reset values on the next cycle. A LOAD in the same cycle as CLR is ignored.
- PDATAIN is only sampled on edges where LOAD=1. It may change freely at other times.

Test Plan:
- Single frame, MSB-first: CLR, then LOAD with ch0=40'h80_0000_0001, ch1=40'h00_0000_0000. Lane0 shows 1, then 38 zeros, then 1. Lane1 all 0. OutReady high exactly 40 cycles. FRAME_START high on cycle 1 only. Then IDLE with DATAOUT=0.
- LSB_FIRST=1, DATA_W=8, NUM_CH=1: LOAD 8'hB4. Lane sequence is 0,0,1,0,1,1,0,1. OutReady high 8 cycles.
- Back-to-back: LOAD word A, then LOAD word B at cnt=10. BUF_FULL=1 from cnt=11 until the handoff. B's first bit follows A's last bit with no gap. OutReady continuous for 80 cycles. Two FRAME_START pulses, 40 cycles apart.
- Overrun: LOAD A, LOAD B at cnt=5, LOAD C at cnt=6. OVERRUN=1 from cnt=7 and remains 1. Lanes send A then B only.
- Boundary: LOAD B at cnt==DATA_W-1 with hold empty gives a gapless transition and OVERRUN=0. Repeat with hold full and LOAD C at cnt==DATA_W-1: B is sent next, C lands in hold and is sent third, OVERRUN=0.
- Reset mid-frame: CLR at cnt=20 with hold full, LOAD also high. Next cycle all outputs are 0 and BUF_FULL=0. A new LOAD afterwards starts cleanly at bit 0.
